inst_encoder_writer: RTL and testbench
======================================

// Module: inst_encoder_writer
// PURPOSE
//  Inverse of the instruction decoder: takes decoded instruction fields (op, func, rd, rs1, rs2, imm) over a
//  valid/ready handshake, packs them into the 32-bit ISA word, and writes it into instruction memory at an
//  auto-incrementing address. Used by the bench/boot loader to program IMEM. Catches bad opcodes and bad immediates.
// PARAMETERS
//  ADDR_W     10      IMEM word-address width
//  BASE_ADDR  0       first word address written after reset/rewind
//  DEPTH      1024    number of writable words from BASE_ADDR (BASE_ADDR+DEPTH <= 2**ADDR_W)
// PORTS
//  clk        in   1       clock, all logic rising-edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       field bundle valid
//  in_ready   out  1       block can accept a bundle
//  in_op      in   4       opcode: ALUR=0 CMPR=2 SW=5 BRANCH=6 ALUI=8 LW=9 CMPI=A JAL=B
//  in_func    in   4       function field
//  in_rd      in   4       destination register
//  in_rs1     in   4       source 1 (SW/BRANCH: the reg in bits [31:28])
//  in_rs2     in   4       source 2 (SW/BRANCH: the reg in bits [27:24])
//  in_imm     in   32      immediate, must fit signed 16-bit
//  rewind     in   1       restart address at BASE_ADDR, clear full
//  err_clr    in   1       acknowledge error
//  imem_we    out  1       one-cycle write strobe
//  imem_addr  out  ADDR_W  write address
//  imem_wdata out  32      encoded word
//  wr_count   out  ADDR_W+1 words written since reset/rewind
//  full       out  1       DEPTH words written
//  err_valid  out  1       sticky error flag
//  err_code   out  2       1=illegal op, 2=imm out of range
// BEHAVIOUR
//  Reset: state IDLE; in_ready=0 during reset, 1 the cycle after; imem_we=0, imem_addr=BASE_ADDR,
//   imem_wdata=0, wr_count=0, full=0, err_valid=0, err_code=0.
//  Encoding (imm16=in_imm[15:0]):
//   ALUR,CMPR:            {rd, rs1, rs2, 12'h000, func, op}
//   ALUI,LW,CMPI,JAL:     {rd, rs1, imm16, func, op}
//   SW,BRANCH:            {rs1, rs2, imm16, func, op}
//   Register forms ignore in_imm (no range check).
//  Imm check (imm forms only): legal iff in_imm[31:15] is all 0s or all 1s.
//  FSM IDLE/WRITE/ERR:
//   IDLE: in_ready = !full && !err_valid. Accept on in_valid&&in_ready: latch encoded word into imem_wdata.
//     Legal -> WRITE. Illegal op -> ERR, err_code=1. Bad imm -> ERR, err_code=2. Illegal op wins if both.
//   WRITE: imem_we=1 for exactly this cycle at the current imem_addr. Next edge: imem_addr+=1, wr_count+=1;
//     full=1 if wr_count reaches DEPTH (imem_addr then holds BASE_ADDR+DEPTH-1, no wrap). -> IDLE.
//   ERR: err_valid=1, in_ready=0, no write, address unchanged. err_clr -> IDLE, err_valid=0, err_code=0.
//  Throughput: one word per 2 cycles; accept-to-strobe latency 1 cycle. in_ready=0 in WRITE and ERR.
//  rewind (IDLE or ERR only; ignored in WRITE so the in-flight write completes): imem_addr=BASE_ADDR,
//   wr_count=0, full=0; err state untouched. rewind and accept in the same IDLE cycle: rewind first,
//   word written at BASE_ADDR.
//  Full: in_ready stays 0; in_valid is ignored until rewind or reset.
//  Reset mid-WRITE: the strobe is dropped the next cycle; no address/count update.
//  imem_wdata holds the last encoded word until the next accept.
// TESTING
//  1 ALUI rd=3 rs1=1 imm=-5 func=0 -> we pulse 1 cycle after accept, addr 0, wdata 32'h31FFFB08.
//  2 SW rs1=2 rs2=4 imm=8 func=0 then ALUR rd=1 rs1=2 rs2=3 func=7 -> addr0=32'h24000805,
//    addr1=32'h12300070; wr_count=2.
//  3 CMPI imm=32'h0001_0000 -> no we, err_valid=1, err_code=2, in_ready=0; err_clr -> in_ready=1, addr unchanged.
//  4 op=4'h3 with in_imm out of range -> err_code=1, no write.
//  5 DEPTH=4: 4 back-to-back valid words -> full=1 after the 4th, 5th held off (in_ready=0);
//    rewind -> next word written at BASE_ADDR.
//  6 reset asserted in WRITE cycle -> we=0 next cycle, addr=BASE_ADDR, wr_count=0, in_ready=1 after release.

Source files
------------

// File: rtl/inst_encoder_writer.sv
// Packs decoded instruction fields into 32-bit ISA words and streams them into
// instruction memory at an auto-incrementing address, flagging illegal opcodes/immediates.
module inst_encoder_writer #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [3:0]        in_func,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              rewind,
  input  logic              err_clr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              full,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {IDLE, WRITE, ERR} state_t;

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  localparam logic [3:0] OP_ALUR   = 4'h0;
  localparam logic [3:0] OP_CMPR   = 4'h2;
  localparam logic [3:0] OP_SW     = 4'h5;
  localparam logic [3:0] OP_BRANCH = 4'h6;
  localparam logic [3:0] OP_ALUI   = 4'h8;
  localparam logic [3:0] OP_LW     = 4'h9;
  localparam logic [3:0] OP_CMPI   = 4'hA;
  localparam logic [3:0] OP_JAL    = 4'hB;

  state_t state, state_nxt;
  logic   accept, bad_op, bad_imm;
  logic [31:0] enc_word;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_ALUR, OP_CMPR, OP_SW, OP_BRANCH,
      OP_ALUI, OP_LW, OP_CMPI, OP_JAL: op_legal = 1'b1;
      default:                         op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_has_imm(input logic [3:0] op);
    case (op)
      OP_SW, OP_BRANCH, OP_ALUI, OP_LW, OP_CMPI, OP_JAL: op_has_imm = 1'b1;
      default:                                           op_has_imm = 1'b0;
    endcase
  endfunction

  // Immediate fits signed 16 bits when the upper 17 bits are a pure sign extension.
  function automatic logic imm_fits(input logic [31:0] imm);
    imm_fits = (imm[31:15] == '0) || (imm[31:15] == '1);
  endfunction

  function automatic logic [31:0] encode(input logic [3:0] op, input logic [3:0] func,
                                         input logic [3:0] rd, input logic [3:0] rs1,
                                         input logic [3:0] rs2, input logic [15:0] imm16);
    case (op)
      OP_SW, OP_BRANCH:                  encode = {rs1, rs2, imm16, func, op};
      OP_ALUI, OP_LW, OP_CMPI, OP_JAL:   encode = {rd, rs1, imm16, func, op};
      default:                           encode = {rd, rs1, rs2, 12'h000, func, op};
    endcase
  endfunction

  assign in_ready = !reset && (state == IDLE) && !full && !err_valid;
  assign accept   = in_valid && in_ready;
  assign bad_op   = !op_legal(in_op);
  assign bad_imm  = op_has_imm(in_op) && !imm_fits(in_imm);
  assign enc_word = encode(in_op, in_func, in_rd, in_rs1, in_rs2, in_imm[15:0]);
  assign imem_we  = (state == WRITE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bad_op || bad_imm) ? ERR : WRITE;
      WRITE:   state_nxt = IDLE;
      ERR:     if (err_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      imem_addr  <= BASE_A;
      imem_wdata <= '0;
      wr_count   <= '0;
      full       <= 1'b0;
      err_valid  <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // Rewind lands before any same-cycle accept, so that word goes to BASE_ADDR.
          if (rewind) begin
            imem_addr <= BASE_A;
            wr_count  <= '0;
            full      <= 1'b0;
          end
          if (accept) begin
            imem_wdata <= enc_word;
            if (bad_op) begin
              err_valid <= 1'b1;
              err_code  <= 2'd1;
            end else if (bad_imm) begin
              err_valid <= 1'b1;
              err_code  <= 2'd2;
            end
          end
        end
        WRITE: begin
          wr_count <= wr_count + 1'b1;
          if (wr_count + 1'b1 == DEPTH_C) full <= 1'b1;
          else                            imem_addr <= imem_addr + 1'b1;
        end
        ERR: begin
          if (rewind) begin
            imem_addr <= BASE_A;
            wr_count  <= '0;
            full      <= 1'b0;
          end
          if (err_clr) begin
            err_valid <= 1'b0;
            err_code  <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder_writer.sv
// Bench for inst_encoder_writer: directed table, corner sequences and random
// transactions checked against an arithmetic reference model.
module tb_inst_encoder_writer;

  localparam int ADDR_W = 10;
  localparam int BASE   = 0;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset, in_valid, in_ready, rewind, err_clr;
  logic [3:0]        in_op, in_func, in_rd, in_rs1, in_rs2;
  logic [31:0]       in_imm;
  logic              imem_we, full, err_valid;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   wr_count;
  logic [1:0]        err_code;

  always #5 clk = ~clk;

  inst_encoder_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_func(in_func), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .rewind(rewind), .err_clr(err_clr), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .wr_count(wr_count), .full(full),
    .err_valid(err_valid), .err_code(err_code)
  );

  int checks = 0;
  int errors = 0;
  int unsigned mdl_addr, mdl_count;
  bit mdl_full;

  typedef struct {
    logic [3:0]  op, func, rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] word;
    int          err;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int ref_err(input logic [3:0] op, input logic [31:0] imm);
    int s = $signed(imm);
    if (!(op inside {4'h0, 4'h2, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB})) return 1;
    if (op inside {4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB} && (s < -32768 || s > 32767)) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [3:0] op, func, rd, rs1, rs2,
                                           input logic [31:0] imm);
    int unsigned i16 = imm % 65536;
    int unsigned r   = 32'(op) + 32'(func) * 16;
    if (op inside {4'h0, 4'h2})
      r += 32'(rs2) * (1 << 20) + 32'(rs1) * (1 << 24) + 32'(rd) * (1 << 28);
    else if (op inside {4'h5, 4'h6})
      r += i16 * 256 + 32'(rs2) * (1 << 24) + 32'(rs1) * (1 << 28);
    else
      r += i16 * 256 + 32'(rs1) * (1 << 24) + 32'(rd) * (1 << 28);
    return r;
  endfunction

  task automatic mdl_rewind();
    mdl_addr = BASE; mdl_count = 0; mdl_full = 0;
  endtask

  task automatic pulse_rewind();
    @(negedge clk); rewind = 1'b1;
    @(negedge clk); rewind = 1'b0;
    mdl_rewind();
    chk("rewind_full", 32'(full), 32'd0);
    chk("rewind_addr", 32'(imem_addr), 32'(BASE));
  endtask

  task automatic do_txn(input logic [3:0] op, func, rd, rs1, rs2, input logic [31:0] imm,
                        input logic [31:0] w, input int e);
    if (mdl_full) pulse_rewind();
    @(negedge clk);
    chk("ready_idle", 32'(in_ready), 32'd1);
    in_op = op; in_func = func; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    if (e == 0) begin
      chk("we_strobe", 32'(imem_we), 32'd1);
      chk("we_addr", 32'(imem_addr), mdl_addr);
      chk("wdata", imem_wdata, w);
      chk("ready_write", 32'(in_ready), 32'd0);
      @(negedge clk);
      mdl_count++;
      if (mdl_count == DEPTH) mdl_full = 1; else mdl_addr++;
      chk("we_drop", 32'(imem_we), 32'd0);
      chk("addr_next", 32'(imem_addr), mdl_addr);
      chk("wr_count", 32'(wr_count), mdl_count);
      chk("full", 32'(full), 32'(mdl_full));
      chk("wdata_hold", imem_wdata, w);
      chk("ready_after", 32'(in_ready), 32'(!mdl_full));
    end else begin
      chk("err_no_we", 32'(imem_we), 32'd0);
      chk("err_valid", 32'(err_valid), 32'd1);
      chk("err_code", 32'(err_code), 32'(e));
      chk("err_ready", 32'(in_ready), 32'd0);
      chk("err_addr", 32'(imem_addr), mdl_addr);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("clr_valid", 32'(err_valid), 32'd0);
      chk("clr_code", 32'(err_code), 32'd0);
      chk("clr_ready", 32'(in_ready), 32'(!mdl_full));
      chk("clr_addr", 32'(imem_addr), mdl_addr);
      chk("clr_count", 32'(wr_count), mdl_count);
    end
  endtask

  initial begin
    vt[0] = '{4'h8, 4'h0, 4'h3, 4'h1, 4'h0, 32'hFFFF_FFFB, 32'h31FF_FB08, 0};
    vt[1] = '{4'h5, 4'h0, 4'h0, 4'h2, 4'h4, 32'h0000_0008, 32'h2400_0805, 0};
    vt[2] = '{4'h0, 4'h7, 4'h1, 4'h2, 4'h3, 32'h0000_0000, 32'h1230_0070, 0};
    vt[3] = '{4'hA, 4'h0, 4'h1, 4'h1, 4'h0, 32'h0001_0000, 32'h0,         2};
    vt[4] = '{4'h3, 4'h0, 4'h1, 4'h1, 4'h1, 32'h0100_0000, 32'h0,         1};
    vt[5] = '{4'h9, 4'h2, 4'h5, 4'h6, 4'h0, 32'h0000_7FFF, 32'h567F_FF29, 0};
    vt[6] = '{4'h6, 4'h1, 4'h0, 4'h7, 4'h8, 32'hFFFF_8000, 32'h7880_0016, 0};
    vt[7] = '{4'hB, 4'h0, 4'h1, 4'h1, 4'h0, 32'h0000_8000, 32'h0,         2};
    vt[8] = '{4'h2, 4'hC, 4'hF, 4'hE, 4'hD, 32'h1234_5678, 32'hFED0_00C2, 0};

    reset = 1'b1; in_valid = 1'b0; rewind = 1'b0; err_clr = 1'b0;
    in_op = '0; in_func = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'(BASE));
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(wr_count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err_valid), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    reset = 1'b0;
    mdl_rewind();
    @(negedge clk);
    chk("ready_post_rst", 32'(in_ready), 32'd1);

    foreach (vt[i])
      do_txn(vt[i].op, vt[i].func, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm, vt[i].word, vt[i].err);

    // Fill to DEPTH, hold off a fifth word, then rewind while it is pending.
    pulse_rewind();
    for (int k = 0; k < DEPTH; k++)
      do_txn(4'h8, 4'(k), 4'h3, 4'h1, 4'h0, 32'(k), ref_word(4'h8, 4'(k), 4'h3, 4'h1, 4'h0, 32'(k)), 0);
    chk("full_set", 32'(full), 32'd1);
    chk("full_addr", 32'(imem_addr), 32'(BASE + DEPTH - 1));
    chk("full_count", 32'(wr_count), 32'(DEPTH));
    @(negedge clk);
    in_op = 4'h8; in_func = 4'h0; in_rd = 4'h3; in_rs1 = 4'h1; in_rs2 = 4'h0; in_imm = 32'hFFFF_FFFB;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("holdoff_ready", 32'(in_ready), 32'd0);
      chk("holdoff_we", 32'(imem_we), 32'd0);
    end
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    chk("rw_full", 32'(full), 32'd0);
    chk("rw_count", 32'(wr_count), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rw_we", 32'(imem_we), 32'd1);
    chk("rw_addr", 32'(imem_addr), 32'(BASE));
    chk("rw_wdata", imem_wdata, 32'h31FF_FB08);
    @(negedge clk);
    chk("rw_count1", 32'(wr_count), 32'd1);

    // Rewind and accept in the same cycle: the word lands at BASE.
    rewind = 1'b1; in_valid = 1'b1;
    in_op = 4'h5; in_func = 4'h0; in_rd = 4'h0; in_rs1 = 4'h2; in_rs2 = 4'h4; in_imm = 32'd8;
    @(negedge clk);
    rewind = 1'b0; in_valid = 1'b0;
    chk("rwacc_we", 32'(imem_we), 32'd1);
    chk("rwacc_addr", 32'(imem_addr), 32'(BASE));
    chk("rwacc_wdata", imem_wdata, 32'h2400_0805);
    @(negedge clk);
    chk("rwacc_count", 32'(wr_count), 32'd1);
    chk("rwacc_addr1", 32'(imem_addr), 32'(BASE + 1));
    mdl_addr = BASE + 1; mdl_count = 1; mdl_full = 0;

    // Reset landing on the write cycle drops the strobe and the update.
    in_op = 4'h0; in_func = 4'h7; in_rd = 4'h1; in_rs1 = 4'h2; in_rs2 = 4'h3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rstw_we", 32'(imem_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_we_drop", 32'(imem_we), 32'd0);
    chk("rstw_addr", 32'(imem_addr), 32'(BASE));
    chk("rstw_count", 32'(wr_count), 32'd0);
    chk("rstw_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    mdl_rewind();
    @(negedge clk);
    chk("rstw_ready_rel", 32'(in_ready), 32'd1);

    for (int n = 0; n < 80; n++) begin
      logic [3:0]  op, fu, rd, r1, r2;
      logic [31:0] imm;
      op = 4'($urandom_range(0, 15)); fu = 4'($urandom); rd = 4'($urandom);
      r1 = 4'($urandom); r2 = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 65535)) - 32'd32768;
        2: begin
          case ($urandom_range(0, 3))
            0:       imm = 32'd32767;
            1:       imm = 32'hFFFF_8000;
            2:       imm = 32'd32768;
            default: imm = 32'hFFFF_7FFF;
          endcase
        end
        default: imm = 32'($urandom_range(0, 255));
      endcase
      do_txn(op, fu, rd, r1, r2, imm, ref_word(op, fu, rd, r1, r2, imm), ref_err(op, imm));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
